// File: rtl/counter_cmd_arbiter_pkg.sv
// Shared definitions for the display-counter command arbiter.
//   CMD_W          : opcode width carried on each requester's cmd lane
//   CMD_NOP..LOAD  : opcode encodings; 110/111 are reserved
//   state_e        : arbiter FSM states
package counter_cmd_arbiter_pkg;

  localparam int CMD_W = 3;

  localparam logic [CMD_W-1:0] CMD_NOP   = 3'b000;
  localparam logic [CMD_W-1:0] CMD_CLEAR = 3'b001;
  localparam logic [CMD_W-1:0] CMD_RUN   = 3'b010;
  localparam logic [CMD_W-1:0] CMD_STOP  = 3'b011;
  localparam logic [CMD_W-1:0] CMD_STEP  = 3'b100;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/counter_cmd_arbiter_if.sv
// Requester-side 4-phase handshake bundle, one lane per requester.
//   req  : level request (requester clock domain)
//   cmd  : opcode, stable while req is high
//   data : LOAD value, stable while req is high
//   ack  : level acknowledge (arbiter clock domain)
// master = requesters, slave = arbiter.
interface counter_cmd_arbiter_if
  import counter_cmd_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) ();

  logic [N_REQ-1:0]            req;
  logic [N_REQ-1:0][CMD_W-1:0] cmd;
  logic [N_REQ-1:0][WIDTH-1:0] data;
  logic [N_REQ-1:0]            ack;

  modport master (output req, cmd, data, input ack);
  modport slave  (input req, cmd, data, output ack);

endinterface

// File: rtl/counter_cmd_arbiter_req_sync.sv
// Single-bit multi-flop synchroniser with asynchronous clear.
//   slower_clock : destination clock
//   rst          : async active-high clear
//   d_i          : asynchronous level input
//   q_o          : synchronised level
module req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic slower_clock,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/counter_cmd_arbiter.sv
// Round-robin command arbiter in front of the shared display counter.
//   slower_clock : block clock
//   rst          : async active-high reset
//   bus          : N_REQ req/cmd/data/ack handshake lanes (slave side)
//   count_o      : counter value
//   running_o    : auto-increment enabled
//   wrap_o       : one-cycle pulse when count steps from all-ones to 0
//   cmd_err_o    : one-cycle pulse when a reserved opcode executes
//   grant_id_o   : last/current granted requester
module counter_cmd_arbiter
  import counter_cmd_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       slower_clock,
  input  logic                       rst,
  counter_cmd_arbiter_if.slave       bus,
  output logic [WIDTH-1:0]           count_o,
  output logic                       running_o,
  output logic                       wrap_o,
  output logic                       cmd_err_o,
  output logic [$clog2(N_REQ)-1:0]   grant_id_o
);

  localparam int GW = $clog2(N_REQ);

  // Returns {found, index}: first pending requester at or above ptr,
  // wrapping. Scanning downward lets the entry nearest ptr win.
  function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] pend,
                                          input logic [GW-1:0]    ptr);
    logic [GW:0]   res;
    logic [GW-1:0] sel;
    int            idx;
    res = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      sel = GW'(idx);
      if (pend[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  logic [N_REQ-1:0] req_s;
  logic [N_REQ-1:0] ack_vec;
  logic             exec;
  logic [GW:0]      pick;

  state_e           state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    ptr_q,   ptr_d;
  logic [CMD_W-1:0] cmd_q,   cmd_d;
  logic [WIDTH-1:0] data_q,  data_d;

  logic [WIDTH-1:0] count_q,   count_d;
  logic             running_q, running_d;
  logic             wrap_q,    wrap_d;
  logic             err_q,     err_d;

  // Only req crosses domains; cmd/data are held stable by the protocol
  // from before req rises until ack is seen, so they are sampled raw.
  req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [N_REQ-1:0] (
    .slower_clock (slower_clock),
    .rst          (rst),
    .d_i          (bus.req),
    .q_o          (req_s)
  );

  assign pick = rr_pick(req_s & ~ack_vec, ptr_q);

  // FSM state register (also holds the latched command)
  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cmd_q   <= CMD_NOP;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick[GW]) begin
          grant_d = pick[GW-1:0];
          cmd_d   = bus.cmd[pick[GW-1:0]];
          data_d  = bus.data[pick[GW-1:0]];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: state_d = ST_ACK;
      ST_ACK: begin
        // Release only once the requester has dropped req; the served
        // requester then becomes lowest priority.
        if (!req_s[grant_q]) begin
          state_d = ST_IDLE;
          ptr_d   = (grant_q == GW'(N_REQ-1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ack_vec = '0;
    exec    = 1'b0;
    case (state_q)
      ST_EXEC: exec = 1'b1;
      ST_ACK:  ack_vec[grant_q] = 1'b1;
      default: ;
    endcase
  end

  // Counter datapath. The free-running increment uses the registered
  // running flag, so RUN starts counting next cycle while STOP kills the
  // increment in its own cycle. STEP while running is just the normal
  // increment, so no double step.
  always_comb begin
    logic             inc;
    logic             ld;
    logic [WIDTH-1:0] ld_val;
    inc       = running_q;
    ld        = 1'b0;
    ld_val    = '0;
    count_d   = count_q;
    running_d = running_q;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (exec) begin
      case (cmd_q)
        CMD_NOP:   ;
        CMD_CLEAR: ld = 1'b1;
        CMD_RUN:   running_d = 1'b1;
        CMD_STOP:  begin running_d = 1'b0; inc = 1'b0; end
        CMD_STEP:  inc = 1'b1;
        CMD_LOAD:  begin ld = 1'b1; ld_val = data_q; end
        default:   err_d = 1'b1;
      endcase
    end
    if (ld) begin
      count_d = ld_val;
    end else if (inc) begin
      count_d = count_q + 1'b1;
      wrap_d  = (count_q == '1);
    end
  end

  always_ff @(posedge slower_clock or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      err_q     <= err_d;
    end
  end

  assign bus.ack    = ack_vec;
  assign count_o    = count_q;
  assign running_o  = running_q;
  assign wrap_o     = wrap_q;
  assign cmd_err_o  = err_q;
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
module tb_counter_cmd_arbiter;
  import counter_cmd_arbiter_pkg::*;

  localparam int N = 4;
  localparam int W = 8;
  localparam int S = 2;

  logic         slower_clock = 1'b0;
  logic         rst;
  logic [W-1:0] count;
  logic         running, wrap, cmd_err;
  logic [1:0]   gid;

  counter_cmd_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  counter_cmd_arbiter #(.N_REQ(N), .WIDTH(W), .SYNC_STAGES(S)) dut (
    .slower_clock (slower_clock),
    .rst          (rst),
    .bus          (bus),
    .count_o      (count),
    .running_o    (running),
    .wrap_o       (wrap),
    .cmd_err_o    (cmd_err),
    .grant_id_o   (gid)
  );

  always #5 slower_clock = ~slower_clock;

  int cyc = 0;
  always @(posedge slower_clock) cyc <= cyc + 1;

  typedef struct {int id; int cyc; logic [7:0] cnt; logic run;} ackx_t;
  typedef struct {int cyc; bit chk_cnt; logic [7:0] cnt; logic run;
                  bit chk_ack; logic [3:0] ack; logic [1:0] gid;} samp_t;

  ackx_t ack_q[$];
  samp_t samp_q[$];
  int    wrap_q[$];
  int    err_q[$];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: pops expectations when the DUT presents ack edges, pulses
  // or reaches a cycle with a timed expectation.
  logic [3:0] ack_prev = '0;
  always @(negedge slower_clock) begin
    logic [3:0] rise;
    ackx_t      e;
    samp_t      s;
    chk("one_ack_max", 32'($countones(bus.ack) <= 1), 1);
    rise     = bus.ack & ~ack_prev;
    ack_prev = bus.ack;
    if (rise != 0) begin
      if (ack_q.size() == 0) chk("unexpected_ack", rise, 0);
      else begin
        e = ack_q.pop_front();
        chk("ack_id", rise, 32'(1 << e.id));
        chk("ack_grant_id", gid, e.id);
        chk("ack_count", count, e.cnt);
        chk("ack_running", running, e.run);
        if (e.cyc >= 0) chk("ack_latency_cycle", cyc, e.cyc);
      end
    end
    if (wrap === 1'b1) begin
      if (wrap_q.size() == 0) chk("unexpected_wrap", wrap, 0);
      else begin
        chk("wrap_cycle", cyc, wrap_q.pop_front());
        chk("wrap_count", count, 0);
      end
    end
    if (cmd_err === 1'b1) begin
      if (err_q.size() == 0) chk("unexpected_cmd_err", cmd_err, 0);
      else chk("cmd_err_cycle", cyc, err_q.pop_front());
    end
    for (int i = samp_q.size() - 1; i >= 0; i--) begin
      s = samp_q[i];
      if (s.cyc < cyc) begin
        chk("sample_missed", s.cyc, cyc);
        samp_q.delete(i);
      end else if (s.cyc == cyc) begin
        if (s.chk_cnt) begin
          chk("count", count, s.cnt);
          chk("running", running, s.run);
        end
        if (s.chk_ack) begin
          chk("ack", bus.ack, s.ack);
          chk("grant_id", gid, s.gid);
        end
        samp_q.delete(i);
      end
    end
  end

  task automatic align();
    @(posedge slower_clock);
    #1;
  endtask

  task automatic wait_ack(input int id, input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge slower_clock);
      if (bus.ack[id] === lvl) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ack_wait_timeout", bus.ack[id], lvl);
  endtask

  // Full 4-phase handshake; checks ack stays up S cycles after req drops
  // is seen, and is gone the cycle after.
  task automatic hs(input int id);
    bit ok;
    int a;
    bus.req[id] = 1'b1;
    wait_ack(id, 1'b1, ok);
    a = cyc;
    bus.req[id] = 1'b0;
    if (ok) begin
      samp_q.push_back('{a+S,   1'b0, 8'h00, 1'b0, 1'b1, 4'(1 << id), 2'(id)});
      samp_q.push_back('{a+S+1, 1'b0, 8'h00, 1'b0, 1'b1, 4'h0,        2'(id)});
    end
    wait_ack(id, 1'b0, ok);
  endtask

  // Caller aligns first (posedge + 1), so ack is due S+2 cycles later.
  task automatic do_cmd(input int id, input logic [2:0] op, input logic [7:0] d,
                        input logic [7:0] ec, input logic er);
    ack_q.push_back('{id, cyc + S + 2, ec, er});
    bus.cmd[id]  = op;
    bus.data[id] = d;
    hs(id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, ra, r;
    bit ok;
    bus.req  = '0;
    bus.cmd  = '0;
    bus.data = '0;
    rst      = 1'b1;
    repeat (3) @(posedge slower_clock);
    #1 rst = 1'b0;
    r = cyc;
    samp_q.push_back('{r+5,  1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 2'd0});
    samp_q.push_back('{r+20, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 2'd0});
    repeat (22) @(posedge slower_clock);

    // LOAD 0xFE, then RUN: FE -> FF -> 00 (wrap) -> 01
    align(); do_cmd(0, CMD_LOAD, 8'hFE, 8'hFE, 1'b0);
    align();
    a = cyc + S + 2; ra = a;
    samp_q.push_back('{a+1, 1'b1, 8'hFF, 1'b1, 1'b0, 4'h0, 2'd0});
    samp_q.push_back('{a+2, 1'b1, 8'h00, 1'b1, 1'b0, 4'h0, 2'd0});
    samp_q.push_back('{a+3, 1'b1, 8'h01, 1'b1, 1'b0, 4'h0, 2'd0});
    wrap_q.push_back(a + 2);
    do_cmd(0, CMD_RUN, 8'h00, 8'hFE, 1'b1);

    // STEP while running: plain one-per-cycle progression
    align();
    a = cyc + S + 2;
    samp_q.push_back('{a+1, 1'b1, 8'(8'hFE + a + 1 - ra), 1'b1, 1'b0, 4'h0, 2'd0});
    do_cmd(1, CMD_STEP, 8'h00, 8'(8'hFE + a - ra), 1'b1);

    // STOP: no increment in its own cycle, frozen afterwards
    align();
    a = cyc + S + 2;
    samp_q.push_back('{a+3, 1'b1, 8'(8'hFE + a - 1 - ra), 1'b0, 1'b0, 4'h0, 2'd0});
    do_cmd(1, CMD_STOP, 8'h00, 8'(8'hFE + a - 1 - ra), 1'b0);

    align(); do_cmd(1, CMD_LOAD, 8'h10, 8'h10, 1'b0);
    align(); do_cmd(1, CMD_STEP, 8'h00, 8'h11, 1'b0);
    align(); do_cmd(1, CMD_STEP, 8'h00, 8'h12, 1'b0);
    align(); do_cmd(1, CMD_STEP, 8'h00, 8'h13, 1'b0);

    // Serve req3 so the pointer wraps to 0
    align(); do_cmd(3, CMD_NOP, 8'hAA, 8'h13, 1'b0);

    // All four at once from pointer 0 -> 0,1,2,3
    for (int i = 0; i < N; i++) begin
      ack_q.push_back('{i, -1, 8'h13, 1'b0});
      bus.cmd[i] = CMD_NOP;
    end
    align();
    fork hs(0); hs(1); hs(2); hs(3); join

    // Serve req0 alone -> pointer 1, then all four -> 1,2,3,0
    align(); do_cmd(0, CMD_NOP, 8'h00, 8'h13, 1'b0);
    ack_q.push_back('{1, -1, 8'h13, 1'b0});
    ack_q.push_back('{2, -1, 8'h13, 1'b0});
    ack_q.push_back('{3, -1, 8'h13, 1'b0});
    ack_q.push_back('{0, -1, 8'h13, 1'b0});
    align();
    fork hs(0); hs(1); hs(2); hs(3); join

    // Reserved opcode: error pulse in the execute cycle, state untouched
    align();
    a = cyc + S + 2;
    err_q.push_back(a);
    samp_q.push_back('{a+2, 1'b1, 8'h13, 1'b0, 1'b0, 4'h0, 2'd0});
    do_cmd(2, 3'b111, 8'h55, 8'h13, 1'b0);

    align(); do_cmd(3, CMD_RUN, 8'h00, 8'h13, 1'b1);

    // Reset while req3 CLEAR sits in ACK with the counter running
    align();
    a = cyc + S + 2;
    ack_q.push_back('{3, a, 8'h00, 1'b1});
    samp_q.push_back('{a,   1'b1, 8'h00, 1'b1, 1'b1, 4'h8, 2'd3});
    samp_q.push_back('{a+1, 1'b1, 8'h01, 1'b1, 1'b1, 4'h8, 2'd3});
    samp_q.push_back('{a+2, 1'b1, 8'h00, 1'b0, 1'b1, 4'h0, 2'd0});
    bus.cmd[3]  = CMD_CLEAR;
    bus.data[3] = 8'h77;
    bus.req[3]  = 1'b1;
    wait_ack(3, 1'b1, ok);
    @(posedge slower_clock);
    @(posedge slower_clock);
    #1 rst = 1'b1;
    @(posedge slower_clock);
    @(posedge slower_clock);
    #1 rst = 1'b0;
    r = cyc;
    ack_q.push_back('{3, r + S + 2, 8'h00, 1'b0});
    wait_ack(3, 1'b1, ok);
    bus.req[3] = 1'b0;
    wait_ack(3, 1'b0, ok);

    repeat (5) @(posedge slower_clock);
    chk("ack_queue_drained",    ack_q.size(),  0);
    chk("sample_queue_drained", samp_q.size(), 0);
    chk("wrap_queue_drained",   wrap_q.size(), 0);
    chk("err_queue_drained",    err_q.size(),  0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_cmd_arbiter.md
Name: counter_cmd_arbiter

Overview:
- Sequences the shared slow-domain display counter (the 8-bit counter driving io_led / hedios slots) and arbitrates command access to it among N requesters (host actions, buttons, self-test).
- Requesters sit in faster or unrelated clock domains and talk through a 4-phase req/ack handshake, synchronised internally.
- One command executes at a time, with round-robin fairness; the counter free-runs on slower_clock while RUN is active.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, counter width
- SYNC_STAGES, 2, flops per req synchroniser (>=2)

Ports:
- slower_clock  in  1  block clock
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester level request (4-phase)
- cmd  in  3*N_REQ  per-requester opcode; stable while its req is high
- data  in  WIDTH*N_REQ  per-requester LOAD value; stable while req is high
- ack  out  N_REQ  per-requester level acknowledge
- count  out  WIDTH  counter value
- running  out  1  counter auto-increment enabled
- wrap  out  1  one-cycle pulse when count steps from all-ones to 0
- cmd_err  out  1  one-cycle pulse when a reserved opcode is executed
- grant_id  out  clog2(N_REQ)  index of the last/current granted requester

Behaviour:
- Reset (async, any time): ack=0, count=0, running=0, wrap=0, cmd_err=0, grant_id=0, RR pointer=0, FSM=IDLE, synchronisers cleared.
  - A requester whose req is still high after reset is served again; its command re-executes.
- Opcodes:
  - 000 NOP
  - 001 CLEAR: count<=0
  - 010 RUN: running<=1
  - 011 STOP: running<=0
  - 100 STEP: count+1, only when running=0; no effect when running
  - 101 LOAD: count<=data
  - 110/111 reserved: no effect, cmd_err pulse, still acked
- Each req passes through SYNC_STAGES flops (req_s); cmd/data are sampled directly, legal because they are stable per protocol.
- FSM:
  - IDLE: if any req_s[i] & ~ack[i], grant the first such i searching from the RR pointer upward with wrap. Latch cmd/data, set grant_id, go EXEC.
  - EXEC (1 cycle): apply the command. Go ACK and set ack[g]=1.
  - ACK: hold ack[g]=1 until req_s[g]==0. Then ack[g]=0, RR pointer<=g+1 mod N_REQ, go IDLE.
- Latency: ack rises SYNC_STAGES+2 slower_clock edges after the first edge at which req is sampled high, provided the FSM is idle. ack falls SYNC_STAGES+1 edges after req is sampled low.
- Only one ack is high at a time. Other requests wait; a requester is not re-granted until its own handshake completes.
- Increment when running=1: count+1 every cycle, modulo 2^WIDTH.
  - In an EXEC cycle, CLEAR/LOAD override that cycle's increment.
  - STOP takes effect the same cycle: no increment that cycle.
  - RUN starts incrementing the following cycle.
- wrap is asserted the cycle count becomes 0 through increment or STEP only. CLEAR, LOAD 0 and reset do not assert it.
- Simultaneous requests: RR order only, with no fixed priority. After requester g is served, g gets lowest priority.
- req dropped before ack (protocol violation): if not yet granted, it is ignored. If granted, the command completes, ack pulses high, and ack drops once req_s is seen low.

Decomposition:
- Shared package: opcode constants (CMD_NOP..CMD_LOAD), FSM state enum, CMD_W=3.
- One sub-module `req_sync` (SYNC_STAGES-deep per-bit synchroniser with async clear), instanced N_REQ wide.
- Round-robin pick is a function in the main module.

Test Plan:
- Reset then idle 20 cycles -> count=0, running=0, ack=0, no wrap/cmd_err pulses.
- Req0 LOAD data=0xFE, then req0 RUN -> ack0 rises SYNC_STAGES+2 edges after each req. count=0xFE, then 0xFF, 0x00 with a one-cycle wrap, then 0x01.
- req1 STEP while running -> acked, no extra increment (count advances exactly 1 per cycle). STOP then STEP x3 from 0x10 -> count=0x13.
- req0..req3 raised on the same edge, each holding until ack -> grant_id order 0,1,2,3. Re-raise all after pointer=1 -> order 1,2,3,0. Never two acks high.
- Reserved opcode 111 on req2 -> cmd_err single pulse, ack2 handshake completes, count/running unchanged.
- Assert rst during ACK with req3 held high -> all outputs zero immediately. After release, req3 re-served: CLEAR re-executes and ack3 rises again.
